// File: rtl/boundary_scroll_buf_pkg.sv
// Shared constants, row payload type and FSM state encoding for the boundary scroll buffer.
package boundary_scroll_buf_pkg;

  localparam int unsigned ROWS = 480;
  localparam int unsigned BW   = 10;
  localparam int unsigned NB   = 4;
  localparam int unsigned RW   = NB * BW;
  localparam int unsigned AW   = 9;
  localparam int unsigned VW   = 10;
  localparam int unsigned SW   = 11;

  typedef logic [RW-1:0] row_t;

  localparam row_t INIT_ROW = '0;

  typedef enum logic [1:0] {
    CLEAR  = 2'd0,
    RUN    = 2'd1,
    COMMIT = 2'd2
  } sbuf_state_t;

  // Circular decrement of a row pointer.
  function automatic logic [AW-1:0] wrap_dec(input logic [AW-1:0] p);
    return (p == '0) ? AW'(ROWS - 1) : p - AW'(1);
  endfunction

endpackage

// File: rtl/boundary_scroll_buf_ram.sv
// Simple dual-port synchronous RAM holding one boundary row per scanline.
module boundary_scroll_buf_ram
  import boundary_scroll_buf_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  row_t          wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output row_t          q
);

  row_t mem [ROWS];
  row_t rd_d;
  row_t rd_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Reads return pre-write data on an address collision; invalid reads return zero.
  always_comb begin
    rd_d = '0;
    if (re) begin
      rd_d = mem[raddr];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

  assign q = rd_q;

endmodule

// File: rtl/boundary_scroll_buf.sv
// Frame-synchronised circular buffer of river boundaries; rows commit at vblank and reads apply the scroll offset.
module boundary_scroll_buf
  import boundary_scroll_buf_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  row_t          row_in,
  input  logic          push_req,
  input  logic          frame_start,
  input  logic [VW-1:0] read_row,
  output row_t          row_out,
  output logic          ready,
  output logic          pending,
  output logic          dropped
);

  sbuf_state_t   state_q, state_d;
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic          pending_q, pending_d;
  row_t          staging_q, staging_d;
  row_t          commit_row_q, commit_row_d;
  logic          ready_q, ready_d;
  logic          dropped_q, dropped_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          rd_valid_q, rd_valid_d;

  logic [AW-1:0] head_m1;
  logic [SW-1:0] rd_sum;
  logic          consume;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  row_t          ram_wdata;

  assign head_m1 = wrap_dec(head_q);

  // FSM, staging and write-port control.
  always_comb begin
    state_d      = state_q;
    head_d       = head_q;
    clr_addr_d   = clr_addr_q;
    pending_d    = pending_q;
    staging_d    = staging_q;
    commit_row_d = commit_row_q;
    ready_d      = ready_q;
    dropped_d    = 1'b0;
    consume      = 1'b0;
    ram_we       = 1'b0;
    ram_waddr    = clr_addr_q;
    ram_wdata    = INIT_ROW;

    case (state_q)
      CLEAR: begin
        ram_we     = 1'b1;
        clr_addr_d = clr_addr_q + AW'(1);
        if (clr_addr_q == AW'(ROWS - 1)) begin
          clr_addr_d = '0;
          state_d    = RUN;
          ready_d    = 1'b1;
        end
      end
      RUN: begin
        // Snapshot the staged row so a simultaneous push cannot alter what commits.
        if (frame_start && pending_q) begin
          consume      = 1'b1;
          commit_row_d = staging_q;
          state_d      = COMMIT;
        end
      end
      COMMIT: begin
        ram_we    = 1'b1;
        ram_waddr = head_m1;
        ram_wdata = commit_row_q;
        head_d    = head_m1;
        state_d   = RUN;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase

    if (consume) begin
      pending_d = 1'b0;
    end
    if (push_req) begin
      staging_d = row_in;
      pending_d = 1'b1;
      dropped_d = pending_q && !consume;
    end
  end

  // Read stage 1: scroll-offset address with wrap and validity flag.
  always_comb begin
    rd_sum     = SW'(head_q) + SW'(read_row);
    rd_addr_d  = AW'(rd_sum);
    if (rd_sum >= SW'(ROWS)) begin
      rd_addr_d = AW'(rd_sum - SW'(ROWS));
    end
    rd_valid_d = ready_q && (read_row < VW'(ROWS));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= CLEAR;
      head_q       <= '0;
      clr_addr_q   <= '0;
      pending_q    <= 1'b0;
      staging_q    <= '0;
      commit_row_q <= '0;
      ready_q      <= 1'b0;
      dropped_q    <= 1'b0;
      rd_addr_q    <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      clr_addr_q   <= clr_addr_d;
      pending_q    <= pending_d;
      staging_q    <= staging_d;
      commit_row_q <= commit_row_d;
      ready_q      <= ready_d;
      dropped_q    <= dropped_d;
      rd_addr_q    <= rd_addr_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  boundary_scroll_buf_ram u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (ram_we),
    .waddr   (ram_waddr),
    .wdata   (ram_wdata),
    .re      (rd_valid_q),
    .raddr   (rd_addr_q),
    .q       (row_out)
  );

  assign ready   = ready_q;
  assign pending = pending_q;
  assign dropped = dropped_q;

endmodule
